axi_noc_slice: RTL and testbench
================================

Name: axi_noc_slice

Overview:
- Registered AXI4 slice between a tile's interconnect NoC-facing slave port and the RaveNoC network-interface AXI slave.
- Breaks all combinational valid/ready and payload paths on all five channels at full throughput.
- Bounds outstanding write and read transactions per tile so the NI buffers cannot be overrun.
- Reports live outstanding counts and a sticky protocol-error flag.

Parameters:
MAX_OUT_WR, 4, maximum accepted-but-unresponded write transactions (1..15)
MAX_OUT_RD, 4, maximum accepted-but-uncompleted read transactions (1..15)

Ports:
clk  input  1  core clock
arst  input  1  asynchronous reset, active-high
slv_axi_mosi  input  s_axi_mosi_t  requests from the tile interconnect
slv_axi_miso  output  s_axi_miso_t  responses to the tile interconnect
mst_axi_mosi  output  s_axi_mosi_t  requests to the NoC NI
mst_axi_miso  input  s_axi_miso_t  responses from the NoC NI
wr_outstanding  output  $clog2(MAX_OUT_WR+1)  current write count
rd_outstanding  output  $clog2(MAX_OUT_RD+1)  current read count
protocol_err  output  1  sticky response-without-request flag

Behaviour:
- Clock and reset: one clock `clk`; `arst` is asynchronous, active-high.
- Channel buffers: each channel (AW, W, AR forward; B, R backward) passes through one 2-entry skid buffer.
  - Output valid is registered.
  - Input ready is registered as ~skid_full.
  - Latency is 1 cycle from input handshake to output valid when the buffer is empty.
  - Sustained rate is 1 beat/cycle with both sides ready.
  - Order is preserved per channel, and the payload is passed unmodified.
- Skid buffer states: EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY→ONE on in handshake.
  - ONE→EMPTY on out handshake with no input.
  - ONE→TWO on input with out stalled.
  - TWO→ONE on out handshake; the skid entry moves to main.
  - Input is not accepted in TWO.
  - Simultaneous in and out in ONE stays in ONE, with main reloaded.
- Reset (async, any time, including mid-burst):
  - All valids (mst aw/w/ar, slv b/r) go to 0 immediately.
  - All buffers go to EMPTY; buffered data is discarded.
  - Counters go to 0; protocol_err goes to 0.
  - Ready outputs go to 1 after reset.
- Write accounting:
  - wr_outstanding increments on the slv AW handshake.
  - It decrements on the slv B handshake, i.e. when the response is delivered upstream.
  - Simultaneous increment and decrement leaves it unchanged.
  - slv awready = aw_buf_ready AND (wr_outstanding < MAX_OUT_WR), using the registered count only.
  - At MAX with a same-cycle decrement, the AW is not accepted; it can be accepted the next cycle.
- Read accounting:
  - rd_outstanding increments on the slv AR handshake.
  - It decrements on the slv R handshake with rlast=1.
  - Gating of arready follows the same rules as AW.
- W channel is not gated; W beats may precede their AW.
- Underflow:
  - A B delivered, or an R with rlast delivered, while the matching count is 0 sets protocol_err=1.
  - The counter holds at 0.
  - protocol_err is cleared only by reset.
- The counter never exceeds its MAX by construction.
- No AXI IDs, addresses or lengths are interpreted.

Decomposition:
- AXI channel typedefs (s_axi_mosi_t, s_axi_miso_t and their per-channel payload structs) come from ravenoc_pkg; no new typedefs.
- Counter widths are local parameters.
- MAX_OUT_WR/MAX_OUT_RD defaults for the MPSoC tile belong as constants in the shared tile package so the tile top and NI configuration agree.
- Sub-module axi_skid_buffer, parameterized on payload type T, with in_valid/in_ready/in_data and out_valid/out_ready/out_data; instantiated 5 times.

Test Plan:
1. Write, downstream always ready:
   - Stimulus: AW addr 0x9000_0100, len 0; one W beat with wlast.
   - Response: both appear on mst 1 cycle after the slv handshake; wr_outstanding=1.
   - Stimulus: NI returns B OKAY.
   - Response: slv bvalid the next cycle; after the bready handshake, wr_outstanding=0.
2. Backpressure:
   - Stimulus: mst arready=0 for 5 cycles; upstream offers 3 ARs (addr 0x100, 0x200, 0x300).
   - Response: 2 accepted, then slv arready=0.
   - Stimulus: release arready.
   - Response: mst emits 0x100, 0x200, 0x300 in order, none lost or duplicated.
3. Read limit, MAX_OUT_RD=4:
   - Stimulus: offer 6 ARs with no R returned.
   - Response: exactly 4 accepted, rd_outstanding=4, arready low.
   - Stimulus: deliver one R with rlast.
   - Response: count=3; the 5th AR is accepted on the following cycle.
4. Throughput:
   - Stimulus: 16-beat W burst, both sides always ready.
   - Response: 16 consecutive mst W beats, one per cycle; wlast only on beat 16; no bubbles.
5. Reset mid-operation:
   - Stimulus: 2 AW entries buffered and wr_outstanding=2; assert arst for 1 cycle.
   - Response: mst awvalid drops to 0 without waiting for clk; counts 0, protocol_err 0; buffers accept new traffic after release.
6. Protocol error:
   - Stimulus: with wr_outstanding=0, NI drives a B that is delivered upstream.
   - Response: protocol_err=1 and stays 1 across further traffic; wr_outstanding remains 0.

Source files
------------

// File: rtl/axi_noc_slice_pkg.sv
// Tile-level constants shared by the tile top and the NI configuration,
// plus the skid-buffer state encoding.
package axi_noc_slice_pkg;

    localparam int TILE_MAX_OUT_WR = 4;
    localparam int TILE_MAX_OUT_RD = 4;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ravenoc_pkg.sv
// Shared AXI4 channel types used between tile interconnect and the RaveNoC NI.
package ravenoc_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } s_axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
    } s_axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } s_axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } s_axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } s_axi_r_t;

    typedef struct packed {
        s_axi_aw_t aw;
        logic      awvalid;
        s_axi_w_t  w;
        logic      wvalid;
        logic      bready;
        s_axi_ar_t ar;
        logic      arvalid;
        logic      rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic      awready;
        logic      wready;
        s_axi_b_t  b;
        logic      bvalid;
        logic      arready;
        s_axi_r_t  r;
        logic      rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/axi_noc_slice_skid.sv
// Two-entry skid buffer: registered valid, registered ready, full throughput.
module axi_skid_buffer
    import axi_noc_slice_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic arst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_e state_r;
    skid_state_e state_nxt_s;
    logic        out_valid_r;
    logic        in_ready_r;
    logic        in_hs_s;
    logic        out_hs_s;
    logic        load_main_s;
    logic        load_skid_s;
    logic        move_skid_s;
    T            main_r;
    T            skid_r;

    assign in_hs_s   = in_valid & in_ready_r;
    assign out_hs_s  = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

    // State register; valid/ready are registered decodes of the next state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= SKID_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != SKID_EMPTY);
            in_ready_r  <= (state_nxt_s != SKID_TWO);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SKID_EMPTY: begin
                if (in_hs_s) state_nxt_s = SKID_ONE;
                else         state_nxt_s = SKID_EMPTY;
            end
            SKID_ONE: begin
                if (in_hs_s && !out_hs_s)      state_nxt_s = SKID_TWO;
                else if (!in_hs_s && out_hs_s) state_nxt_s = SKID_EMPTY;
                else                           state_nxt_s = SKID_ONE;
            end
            SKID_TWO: begin
                if (out_hs_s) state_nxt_s = SKID_ONE;
                else          state_nxt_s = SKID_TWO;
            end
            default: state_nxt_s = SKID_EMPTY;
        endcase
    end

    // Datapath load controls decoded from state and handshakes.
    always_comb begin
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        case (state_r)
            SKID_EMPTY: load_main_s = in_hs_s;
            SKID_ONE: begin
                load_main_s = in_hs_s & out_hs_s;
                load_skid_s = in_hs_s & ~out_hs_s;
            end
            SKID_TWO: move_skid_s = out_hs_s;
            default: begin
                load_main_s = 1'b0;
                load_skid_s = 1'b0;
                move_skid_s = 1'b0;
            end
        endcase
    end

    // Payload storage; the skid entry promotes to main when main drains.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (load_main_s)      main_r <= in_data;
            else if (move_skid_s) main_r <= skid_r;
            if (load_skid_s)      skid_r <= in_data;
        end
    end

endmodule

// File: rtl/axi_noc_slice.sv
// Registered AXI4 slice toward the RaveNoC NI with outstanding-transaction
// limits and a sticky response-without-request flag.
module axi_noc_slice
    import ravenoc_pkg::*, axi_noc_slice_pkg::*;
#(
    parameter int MAX_OUT_WR = TILE_MAX_OUT_WR,
    parameter int MAX_OUT_RD = TILE_MAX_OUT_RD
) (
    input  logic                            clk,
    input  logic                            arst,
    input  s_axi_mosi_t                     slv_axi_mosi,
    output s_axi_miso_t                     slv_axi_miso,
    output s_axi_mosi_t                     mst_axi_mosi,
    input  s_axi_miso_t                     mst_axi_miso,
    output logic [$clog2(MAX_OUT_WR+1)-1:0] wr_outstanding,
    output logic [$clog2(MAX_OUT_RD+1)-1:0] rd_outstanding,
    output logic                            protocol_err
);

    localparam int WR_CNT_W = $clog2(MAX_OUT_WR + 1);
    localparam int RD_CNT_W = $clog2(MAX_OUT_RD + 1);

    logic [WR_CNT_W-1:0] wr_cnt_r;
    logic [RD_CNT_W-1:0] rd_cnt_r;
    logic                protocol_err_r;

    logic      aw_in_ready_s, w_in_ready_s, ar_in_ready_s, b_in_ready_s, r_in_ready_s;
    logic      mst_aw_valid_s, mst_w_valid_s, mst_ar_valid_s, slv_b_valid_s, slv_r_valid_s;
    s_axi_aw_t mst_aw_s;
    s_axi_w_t  mst_w_s;
    s_axi_ar_t mst_ar_s;
    s_axi_b_t  slv_b_s;
    s_axi_r_t  slv_r_s;

    logic wr_room_s, rd_room_s;
    logic aw_in_valid_s, ar_in_valid_s;
    logic aw_hs_s, ar_hs_s, b_hs_s, r_last_hs_s;
    logic wr_dec_s, rd_dec_s, underflow_s;

    // Gating uses the registered counts only, so a same-cycle release never
    // opens the gate combinationally.
    assign wr_room_s     = (wr_cnt_r < WR_CNT_W'(MAX_OUT_WR));
    assign rd_room_s     = (rd_cnt_r < RD_CNT_W'(MAX_OUT_RD));
    assign aw_in_valid_s = slv_axi_mosi.awvalid & wr_room_s;
    assign ar_in_valid_s = slv_axi_mosi.arvalid & rd_room_s;
    assign aw_hs_s       = aw_in_valid_s & aw_in_ready_s;
    assign ar_hs_s       = ar_in_valid_s & ar_in_ready_s;
    assign b_hs_s        = slv_b_valid_s & slv_axi_mosi.bready;
    assign r_last_hs_s   = slv_r_valid_s & slv_axi_mosi.rready & slv_r_s.last;
    assign wr_dec_s      = b_hs_s & (wr_cnt_r != '0);
    assign rd_dec_s      = r_last_hs_s & (rd_cnt_r != '0);
    assign underflow_s   = (b_hs_s & (wr_cnt_r == '0)) | (r_last_hs_s & (rd_cnt_r == '0));

    axi_skid_buffer #(.T(s_axi_aw_t)) u_aw_buf (
        .clk(clk), .arst(arst),
        .in_valid(aw_in_valid_s), .in_ready(aw_in_ready_s), .in_data(slv_axi_mosi.aw),
        .out_valid(mst_aw_valid_s), .out_ready(mst_axi_miso.awready), .out_data(mst_aw_s)
    );

    axi_skid_buffer #(.T(s_axi_w_t)) u_w_buf (
        .clk(clk), .arst(arst),
        .in_valid(slv_axi_mosi.wvalid), .in_ready(w_in_ready_s), .in_data(slv_axi_mosi.w),
        .out_valid(mst_w_valid_s), .out_ready(mst_axi_miso.wready), .out_data(mst_w_s)
    );

    axi_skid_buffer #(.T(s_axi_ar_t)) u_ar_buf (
        .clk(clk), .arst(arst),
        .in_valid(ar_in_valid_s), .in_ready(ar_in_ready_s), .in_data(slv_axi_mosi.ar),
        .out_valid(mst_ar_valid_s), .out_ready(mst_axi_miso.arready), .out_data(mst_ar_s)
    );

    axi_skid_buffer #(.T(s_axi_b_t)) u_b_buf (
        .clk(clk), .arst(arst),
        .in_valid(mst_axi_miso.bvalid), .in_ready(b_in_ready_s), .in_data(mst_axi_miso.b),
        .out_valid(slv_b_valid_s), .out_ready(slv_axi_mosi.bready), .out_data(slv_b_s)
    );

    axi_skid_buffer #(.T(s_axi_r_t)) u_r_buf (
        .clk(clk), .arst(arst),
        .in_valid(mst_axi_miso.rvalid), .in_ready(r_in_ready_s), .in_data(mst_axi_miso.r),
        .out_valid(slv_r_valid_s), .out_ready(slv_axi_mosi.rready), .out_data(slv_r_s)
    );

    // Assemble the NI-facing request bundle.
    always_comb begin
        mst_axi_mosi         = '0;
        mst_axi_mosi.aw      = mst_aw_s;
        mst_axi_mosi.awvalid = mst_aw_valid_s;
        mst_axi_mosi.w       = mst_w_s;
        mst_axi_mosi.wvalid  = mst_w_valid_s;
        mst_axi_mosi.bready  = b_in_ready_s;
        mst_axi_mosi.ar      = mst_ar_s;
        mst_axi_mosi.arvalid = mst_ar_valid_s;
        mst_axi_mosi.rready  = r_in_ready_s;
    end

    // Assemble the interconnect-facing response bundle.
    always_comb begin
        slv_axi_miso         = '0;
        slv_axi_miso.awready = aw_in_ready_s & wr_room_s;
        slv_axi_miso.wready  = w_in_ready_s;
        slv_axi_miso.b       = slv_b_s;
        slv_axi_miso.bvalid  = slv_b_valid_s;
        slv_axi_miso.arready = ar_in_ready_s & rd_room_s;
        slv_axi_miso.r       = slv_r_s;
        slv_axi_miso.rvalid  = slv_r_valid_s;
    end

    // Outstanding write count: AW accepted upstream to B delivered upstream.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)                      wr_cnt_r <= '0;
        else if (aw_hs_s && !wr_dec_s) wr_cnt_r <= wr_cnt_r + WR_CNT_W'(1);
        else if (!aw_hs_s && wr_dec_s) wr_cnt_r <= wr_cnt_r - WR_CNT_W'(1);
        else                           wr_cnt_r <= wr_cnt_r;
    end

    // Outstanding read count: AR accepted upstream to last R delivered upstream.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)                      rd_cnt_r <= '0;
        else if (ar_hs_s && !rd_dec_s) rd_cnt_r <= rd_cnt_r + RD_CNT_W'(1);
        else if (!ar_hs_s && rd_dec_s) rd_cnt_r <= rd_cnt_r - RD_CNT_W'(1);
        else                           rd_cnt_r <= rd_cnt_r;
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)             protocol_err_r <= 1'b0;
        else if (underflow_s) protocol_err_r <= 1'b1;
        else                  protocol_err_r <= protocol_err_r;
    end

    assign wr_outstanding = wr_cnt_r;
    assign rd_outstanding = rd_cnt_r;
    assign protocol_err   = protocol_err_r;

endmodule

// File: tb/tb_axi_noc_slice.sv
// Directed bench for axi_noc_slice: a per-cycle vector table for the write
// path and protocol error, plus hand sequences for the multi-cycle cases.
module tb_axi_noc_slice;
    import ravenoc_pkg::*;

    logic        clk;
    logic        arst;
    s_axi_mosi_t slv_mosi;
    s_axi_miso_t slv_miso;
    s_axi_mosi_t mst_mosi;
    s_axi_miso_t mst_miso;
    logic [2:0]  wr_out;
    logic [2:0]  rd_out;
    logic        perr;

    int checks = 0;
    int errors = 0;

    axi_noc_slice #(.MAX_OUT_WR(4), .MAX_OUT_RD(4)) dut (
        .clk(clk), .arst(arst),
        .slv_axi_mosi(slv_mosi), .slv_axi_miso(slv_miso),
        .mst_axi_mosi(mst_mosi), .mst_axi_miso(mst_miso),
        .wr_outstanding(wr_out), .rd_outstanding(rd_out),
        .protocol_err(perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        awvalid;
        logic [31:0] awaddr;
        logic        wvalid;
        logic        wlast;
        logic        ni_bvalid;
        logic        e_awvalid;
        logic [31:0] e_awaddr;
        logic        e_wvalid;
        logic        e_bvalid;
        logic [2:0]  e_wr;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_defaults();
        slv_mosi          = '0;
        slv_mosi.bready   = 1'b1;
        slv_mosi.rready   = 1'b1;
        slv_mosi.w.strb   = 4'hF;
        mst_miso          = '0;
        mst_miso.awready  = 1'b1;
        mst_miso.wready   = 1'b1;
        mst_miso.arready  = 1'b1;
    endtask

    task automatic do_reset();
        set_defaults();
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
        tick();
        check("reset_state",
              64'({mst_mosi.awvalid, mst_mosi.wvalid, mst_mosi.arvalid,
                   slv_miso.bvalid, slv_miso.rvalid, wr_out, rd_out, perr,
                   slv_miso.awready, slv_miso.wready, slv_miso.arready,
                   mst_mosi.bready, mst_mosi.rready}),
              64'({5'b00000, 3'd0, 3'd0, 1'b0, 5'b11111}));
    endtask

    initial begin
        int idx;
        int n_out;
        logic acc;
        logic [31:0] addrs[3];
        logic [38:0] got_v;
        logic [38:0] exp_v;

        vecs[0] = '{1'b1, 32'h9000_0100, 1'b1, 1'b1, 1'b0, 1'b1, 32'h9000_0100, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd1, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 3'd1, 1'b0};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd0, 1'b0};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 3'd0, 1'b0};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd0, 1'b1};
        vecs[7] = '{1'b1, 32'h9000_0200, 1'b1, 1'b1, 1'b0, 1'b1, 32'h9000_0200, 1'b1, 1'b0, 3'd1, 1'b1};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd1, 1'b1};

        addrs[0] = 32'h100;
        addrs[1] = 32'h200;
        addrs[2] = 32'h300;

        arst = 1'b1;
        set_defaults();
        #2;
        check("async_reset_valids",
              64'({mst_mosi.awvalid, mst_mosi.wvalid, mst_mosi.arvalid, slv_miso.bvalid, slv_miso.rvalid}),
              64'(5'b00000));
        do_reset();

        // Write round trip followed by an unsolicited B.
        for (int v = 0; v < 9; v++) begin
            slv_mosi.awvalid   = vecs[v].awvalid;
            slv_mosi.aw.addr   = vecs[v].awaddr;
            slv_mosi.wvalid    = vecs[v].wvalid;
            slv_mosi.w.last    = vecs[v].wlast;
            mst_miso.bvalid    = vecs[v].ni_bvalid;
            mst_miso.b.resp    = 2'b00;
            tick();
            got_v = {mst_mosi.awvalid, (mst_mosi.awvalid ? mst_mosi.aw.addr : 32'h0),
                     mst_mosi.wvalid, slv_miso.bvalid, wr_out, perr};
            exp_v = {vecs[v].e_awvalid, vecs[v].e_awaddr, vecs[v].e_wvalid,
                     vecs[v].e_bvalid, vecs[v].e_wr, vecs[v].e_err};
            check($sformatf("vec%0d", v), 64'(got_v), 64'(exp_v));
        end

        // Reset while two AWs are held in the buffer.
        do_reset();
        mst_miso.awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            slv_mosi.awvalid = 1'b1;
            slv_mosi.aw.addr = 32'hA000 + 32'(i * 16);
            tick();
        end
        slv_mosi.awvalid = 1'b0;
        check("rst_pre", 64'({mst_mosi.awvalid, wr_out}), 64'({1'b1, 3'd2}));
        arst = 1'b1;
        #1;
        check("rst_async", 64'({mst_mosi.awvalid, wr_out, rd_out, perr}), 64'({1'b0, 3'd0, 3'd0, 1'b0}));
        @(posedge clk);
        #1;
        arst = 1'b0;
        check("rst_ready", 64'({slv_miso.awready, slv_miso.wready, slv_miso.arready}), 64'(3'b111));
        mst_miso.awready = 1'b1;
        slv_mosi.awvalid = 1'b1;
        slv_mosi.aw.addr = 32'hB000;
        tick();
        slv_mosi.awvalid = 1'b0;
        check("rst_after", 64'({mst_mosi.awvalid, mst_mosi.aw.addr, wr_out}), 64'({1'b1, 32'hB000, 3'd1}));

        // AR backpressure then ordered drain.
        do_reset();
        mst_miso.arready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            slv_mosi.arvalid = (idx < 3);
            if (idx < 3) slv_mosi.ar.addr = addrs[idx];
            acc = slv_mosi.arvalid & slv_miso.arready;
            tick();
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'(2));
        check("bp_arready_low", 64'(slv_miso.arready), 64'(1'b0));
        mst_miso.arready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 12; c++) begin
            slv_mosi.arvalid = (idx < 3);
            if (idx < 3) slv_mosi.ar.addr = addrs[idx];
            acc = slv_mosi.arvalid & slv_miso.arready;
            if (mst_mosi.arvalid && mst_miso.arready) begin
                if (n_out < 3) check($sformatf("bp_order%0d", n_out), 64'(mst_mosi.ar.addr), 64'(addrs[n_out]));
                n_out++;
            end
            tick();
            if (acc) idx++;
        end
        slv_mosi.arvalid = 1'b0;
        check("bp_count_out", 64'(n_out), 64'(3));

        // Read limit at four outstanding.
        do_reset();
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            slv_mosi.arvalid = (idx < 6);
            slv_mosi.ar.addr = 32'h1000 + 32'(idx * 256);
            acc = slv_mosi.arvalid & slv_miso.arready;
            tick();
            if (acc) idx++;
        end
        check("rdlim_accepted", 64'({32'(idx), rd_out, slv_miso.arready}), 64'({32'd4, 3'd4, 1'b0}));
        mst_miso.rvalid = 1'b1;
        mst_miso.r.last = 1'b1;
        tick();
        mst_miso.rvalid = 1'b0;
        check("rdlim_r_buffered", 64'({slv_miso.rvalid, rd_out, slv_miso.arready}), 64'({1'b1, 3'd4, 1'b0}));
        tick();
        check("rdlim_dec", 64'({rd_out, slv_miso.arready}), 64'({3'd3, 1'b1}));
        tick();
        slv_mosi.arvalid = 1'b0;
        check("rdlim_fifth", 64'({rd_out, mst_mosi.arvalid, mst_mosi.ar.addr}), 64'({3'd4, 1'b1, 32'h1400}));

        // Sixteen-beat W burst at full rate.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("w_ready%0d", i), 64'(slv_miso.wready), 64'(1'b1));
            slv_mosi.wvalid = 1'b1;
            slv_mosi.w.data = 32'(i);
            slv_mosi.w.last = (i == 15);
            tick();
            check($sformatf("w_beat%0d", i), 64'({mst_mosi.wvalid, mst_mosi.w.data, mst_mosi.w.last}),
                  64'({1'b1, 32'(i), (i == 15)}));
        end
        slv_mosi.wvalid = 1'b0;
        tick();
        check("w_idle", 64'(mst_mosi.wvalid), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
